mac_pkt_buf: RTL and testbench
==============================

Name: mac_pkt_buf

Overview:
- Parametrised single-clock receive packet buffer for the MAC datapath.
- Sits between the RX CDC FIFO output (clk domain) and the APB register front-end.
- Stores whole frames in a circular word RAM and queues committed frame lengths in a length FIFO.
- Commits good frames and rewinds bad ones (short, long, errored, overflowing); the reader consumes one frame at a time and releases it explicitly.

Parameters:
- DATA_W, 32: data word width in bits; multiple of 8. BPW = DATA_W/8 bytes per word.
- ADDR_W, 9: RAM depth is 2^ADDR_W words.
- LEN_W, 11: frame length width in bytes.
- FRM_DEPTH, 4: length FIFO entries; power of 2, minimum 2.
- MIN_LEN, 60: minimum legal frame length in bytes.
- MAX_LEN, 1518: maximum legal frame length in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  accept new frames; sampled only on the first beat of a frame
- in_valid  in  1  write beat valid; no backpressure
- in_first  in  1  first beat of frame
- in_last  in  1  last beat of frame (may coincide with in_first)
- in_err  in  1  abort the current frame
- in_bytes  in  $clog2(BPW)+1  valid low-order bytes in this beat, 1..BPW
- in_data  in  DATA_W  beat data, byte 0 in bits [7:0]
- frm_avail  out  1  at least one committed frame is queued
- frm_len  out  LEN_W  length of the head frame; 0 when frm_avail=0
- rd_req  in  1  read the next word of the head frame
- rd_valid  out  1  rd_data is valid
- rd_data  out  DATA_W  read word
- frm_done  in  1  release the head frame
- drop_pulse  out  1  one-cycle pulse per dropped frame
- free_words  out  ADDR_W+1  free RAM words, counted from the committed write pointer

Behaviour:
- Reset: all pointers 0; length FIFO empty; write FSM in IDLE. All outputs 0 except free_words = 2^ADDR_W. A partial frame in progress at reset is lost.
- Pointers are ADDR_W+1 bits with a wrap bit:
  - wptr_commit and wptr_work on the write side.
  - rptr_base (head frame start) and rptr (next read) on the read side.
  - used = wptr_work - rptr_base; full when used = 2^ADDR_W.
- RAM: inferred, 1 write port and 1 registered read port; write and read may occur in the same cycle.
- Write FSM states: IDLE, RECV, DROP.
  - IDLE: in_valid & in_first starts a frame. The byte count cnt (LEN_W+1 bits) restarts at in_bytes.
    - Goes to RECV if wr_en=1, else DROP.
    - in_valid without in_first is ignored.
  - RECV, per beat:
    - Go to DROP if in_err, if a non-last beat has in_bytes != BPW, if the buffer is full, or if cnt exceeds MAX_LEN (cnt saturates at MAX_LEN+1).
    - Otherwise write in_data at wptr_work and increment wptr_work.
  - RECV, beat with in_last: commit when all of the following hold; otherwise drop.
    - MIN_LEN <= cnt <= MAX_LEN.
    - The length FIFO is not full, using the count before any same-cycle pop.
    - No overflow occurred.
  - Commit: push cnt into the length FIFO, set wptr_commit = wptr_work, go to IDLE.
  - DROP: discard beats until in_last, then go to IDLE.
  - Any drop: wptr_work rewinds to wptr_commit, and drop_pulse asserts in the cycle after the in_last beat.
  - in_first while in RECV or DROP: the current frame is dropped and the new frame starts (restart rule).
- Read side:
  - frm_len = FIFO head when non-empty.
  - rd_req is accepted only while words remain in the head frame, i.e. rptr - rptr_base < ceil(frm_len/BPW). rd_valid and rd_data appear exactly 1 cycle after an accepted rd_req.
  - Excess rd_req is ignored, and rd_valid stays 0.
  - frm_done with frm_avail=1: pop the FIFO and set rptr = rptr_base = rptr_base + ceil(frm_len/BPW). This allows skipping unread words.
  - frm_done with frm_avail=0 is ignored.
  - frm_done and rd_req in the same cycle: frm_done wins and rd_req is ignored.
  - FIFO push and pop in the same cycle are both honoured, subject to the full rule above.
- free_words = 2^ADDR_W - (wptr_commit - rptr_base), registered with 1-cycle update.

Optional Feature:
- Macro: MAC_PKT_BUF_STAT_EN.
- When defined, adds ports stat_clr (in, 1), stat_frm_cnt (out, 16) and stat_drop_cnt (out, 16).
  - The counters count commits and drops respectively and saturate at 16'hffff.
  - stat_clr zeroes both counters next cycle; a same-cycle event is lost.
  - rst zeroes both counters.
- When undefined, these ports and counters are absent and the block behaves identically otherwise.

Test Plan:
- 64-byte frame (16 beats, in_bytes=4) -> frm_avail=1, frm_len=64. 16 rd_req return the words in order, each with 1-cycle latency; a 17th rd_req gives no rd_valid. After frm_done, frm_avail=0 and free_words=512.
- 61-byte frame (last beat in_bytes=1) -> frm_len=61. frm_done with 3 words unread advances rptr_base by 16; the next frame reads from its correct base.
- 40-byte frame, then a 1600-byte frame, then a frame with in_err on beat 5 -> 3 drop_pulse, frm_avail=0, free_words=512. A following 100-byte frame commits at address 0.
- 5 back-to-back 64-byte frames with no reads (FRM_DEPTH=4) -> 4 commit and the 5th drops. frm_done on the cycle of the 5th in_last still drops it.
- 1500-byte frame commits (375 words); a second 1500-byte frame overflows and drops (free_words=137). After frm_done, a third 1500-byte frame commits.
- rst asserted mid-frame at beat 10 -> all outputs at reset values; remaining beats without in_first are ignored; the next in_first frame commits normally.

Source files
------------

// File: rtl/mac_pkt_buf.sv
// mac_pkt_buf: single-clock receive packet buffer for the MAC datapath.
// Whole frames are written into a circular word RAM and their byte lengths are
// queued in a small length FIFO once the frame is known to be good. Bad frames
// (short, long, errored, overflowing, or with no room in the length FIFO) are
// rewound so they never become visible to the reader. The reader walks the
// head frame word by word and releases it explicitly with frm_done.
//
// Optional build macro: MAC_PKT_BUF_STAT_EN adds stat_clr, stat_frm_cnt and
// stat_drop_cnt (saturating commit/drop counters).

module mac_pkt_buf #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int LEN_W     = 11,
    parameter int FRM_DEPTH = 4,
    parameter int MIN_LEN   = 60,
    parameter int MAX_LEN   = 1518
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic                          in_valid,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic                          in_err,
    input  logic [$clog2(DATA_W/8):0]     in_bytes,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          frm_avail,
    output logic [LEN_W-1:0]              frm_len,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          frm_done,
    output logic                          drop_pulse,
`ifdef MAC_PKT_BUF_STAT_EN
    input  logic                          stat_clr,
    output logic [15:0]                   stat_frm_cnt,
    output logic [15:0]                   stat_drop_cnt,
`endif
    output logic [ADDR_W:0]               free_words
);

    localparam int BPW     = DATA_W / 8;
    localparam int IB_W    = $clog2(BPW) + 1;
    localparam int LOG_BPW = $clog2(BPW);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int FA_W    = $clog2(FRM_DEPTH);

    localparam logic [ADDR_W:0] DEPTH_P  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_A    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0]  MIN_L    = (LEN_W+1)'(MIN_LEN);
    localparam logic [LEN_W:0]  MAX_L    = (LEN_W+1)'(MAX_LEN);
    localparam logic [LEN_W:0]  MAX_SAT  = (LEN_W+1)'(MAX_LEN + 1);
    localparam logic [LEN_W:0]  RND      = (LEN_W+1)'(BPW - 1);
    localparam logic [IB_W-1:0] BPW_B    = IB_W'(BPW);
    localparam logic [FA_W:0]   FRM_FULL = (FA_W+1)'(FRM_DEPTH);
    localparam logic [FA_W:0]   ONE_F    = {{FA_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP
    } wr_state_t;

    // Write-side state
    wr_state_t         r_state;
    wr_state_t         w_state_nxt;
    logic [ADDR_W:0]   r_wptr_commit;
    logic [ADDR_W:0]   r_wptr_work;
    logic [ADDR_W:0]   w_commit_nxt;
    logic [ADDR_W:0]   w_work_nxt;
    logic [ADDR_W:0]   w_wbase;
    logic [ADDR_W:0]   w_used;
    logic [LEN_W:0]    r_cnt;
    logic [LEN_W:0]    w_cnt_nxt;
    logic [LEN_W:0]    w_sum;
    logic [LEN_W:0]    w_beat_cnt;
    logic              w_full;
    logic              w_bad;
    logic              w_len_ok;
    logic              w_proc;
    logic              w_mem_we;
    logic              w_push;
    logic              w_drop;
    logic              r_drop_pulse;

    // Storage
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LEN_W-1:0]  r_lfifo [FRM_DEPTH];
    logic [FA_W:0]     r_lf_wp;
    logic [FA_W:0]     r_lf_rp;
    logic [FA_W:0]     w_lf_cnt;
    logic              w_lf_full;

    // Read-side state
    logic [ADDR_W:0]   r_rptr_base;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   w_rd_off;
    logic [ADDR_W:0]   w_frm_words;
    logic [LEN_W:0]    w_len_rnd;
    logic              w_avail;
    logic              w_pop;
    logic              w_rd_acc;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W:0]   r_free;

    // Length FIFO occupancy and head
    assign w_lf_cnt  = r_lf_wp - r_lf_rp;
    assign w_lf_full = (w_lf_cnt == FRM_FULL);
    assign w_avail   = (w_lf_cnt != '0);
    assign frm_len   = w_avail ? r_lfifo[r_lf_rp[FA_W-1:0]] : '0;

    // Head frame size in words; rd_req is honoured only inside it, and a
    // release always skips the whole frame regardless of how much was read.
    assign w_len_rnd   = {1'b0, frm_len} + RND;
    assign w_frm_words = (ADDR_W+1)'(w_len_rnd >> LOG_BPW);
    assign w_rd_off    = r_rptr - r_rptr_base;
    assign w_pop       = frm_done & w_avail;
    assign w_rd_acc    = rd_req & w_avail & ~frm_done & (w_rd_off < w_frm_words);

    // A new first beat always restarts from the committed pointer, so a frame
    // abandoned by the restart rule is rewound in the same cycle.
    assign w_wbase = (in_valid & in_first) ? r_wptr_commit : r_wptr_work;
    assign w_used  = w_wbase - r_rptr_base;
    assign w_full  = (w_used == DEPTH_P);

    // Running byte count, saturating just above the legal maximum
    assign w_sum      = r_cnt + (LEN_W+1)'(in_bytes);
    assign w_beat_cnt = in_first ? (LEN_W+1)'(in_bytes)
                                 : ((w_sum > MAX_L) ? MAX_SAT : w_sum);

    assign w_bad    = in_err | w_full | (w_beat_cnt > MAX_L)
                    | (~in_last & (in_bytes != BPW_B));
    assign w_len_ok = (w_beat_cnt >= MIN_L) & (w_beat_cnt <= MAX_L);

    // Beats that carry data for a frame being received (first beat with
    // wr_en set, or any continuation beat while receiving)
    assign w_proc = in_valid & ((in_first & wr_en) | (~in_first & (r_state == ST_RECV)));

    // Write FSM next-state: decides store/commit/drop for every input beat
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_work_nxt   = r_wptr_work;
        w_commit_nxt = r_wptr_commit;
        w_mem_we     = 1'b0;
        w_push       = 1'b0;
        w_drop       = 1'b0;

        if (in_valid) begin
            if (in_first) begin
                if (r_state != ST_IDLE) begin
                    w_drop = 1'b1;
                end
                w_work_nxt = r_wptr_commit;
                if (!wr_en) begin
                    if (in_last) begin
                        w_drop      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end else if ((r_state == ST_DROP) && in_last) begin
                w_drop      = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            if (w_proc) begin
                w_cnt_nxt = w_beat_cnt;
                if (w_bad) begin
                    w_work_nxt = r_wptr_commit;
                    if (in_last) begin
                        w_drop      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end else if (in_last) begin
                    if (w_len_ok && !w_lf_full) begin
                        w_mem_we     = 1'b1;
                        w_push       = 1'b1;
                        w_work_nxt   = w_wbase + ONE_A;
                        w_commit_nxt = w_wbase + ONE_A;
                    end else begin
                        w_drop     = 1'b1;
                        w_work_nxt = r_wptr_commit;
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_mem_we    = 1'b1;
                    w_work_nxt  = w_wbase + ONE_A;
                    w_state_nxt = ST_RECV;
                end
            end
        end
    end

    // Write FSM state, write pointers, byte count and drop pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_wptr_work   <= '0;
            r_wptr_commit <= '0;
            r_drop_pulse  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wptr_work   <= w_work_nxt;
            r_wptr_commit <= w_commit_nxt;
            r_drop_pulse  <= w_drop;
        end
    end

    // Frame RAM write port
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wbase[ADDR_W-1:0]] <= in_data;
        end
    end

    // Frame RAM registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rptr[ADDR_W-1:0]];
            end
        end
    end

    // Length FIFO storage; full is judged before any same-cycle pop
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lfifo[r_lf_wp[FA_W-1:0]] <= w_beat_cnt[LEN_W-1:0];
        end
    end

    // Length FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lf_wp <= '0;
            r_lf_rp <= '0;
        end else begin
            if (w_push) begin
                r_lf_wp <= r_lf_wp + ONE_F;
            end
            if (w_pop) begin
                r_lf_rp <= r_lf_rp + ONE_F;
            end
        end
    end

    // Read pointers: release jumps to the next frame, otherwise step per read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr_base <= '0;
            r_rptr      <= '0;
        end else if (w_pop) begin
            r_rptr_base <= r_rptr_base + w_frm_words;
            r_rptr      <= r_rptr_base + w_frm_words;
        end else if (w_rd_acc) begin
            r_rptr <= r_rptr + ONE_A;
        end
    end

    // Free space as seen from committed data, one cycle behind the pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_free <= DEPTH_P;
        end else begin
            r_free <= DEPTH_P - (r_wptr_commit - r_rptr_base);
        end
    end

`ifdef MAC_PKT_BUF_STAT_EN
    logic [15:0] r_stat_frm;
    logic [15:0] r_stat_drop;

    // Saturating commit/drop counters; a clear overrides a same-cycle event
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_stat_frm  <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_push && (r_stat_frm != 16'hffff)) begin
                r_stat_frm <= r_stat_frm + 16'd1;
            end
            if (w_drop && (r_stat_drop != 16'hffff)) begin
                r_stat_drop <= r_stat_drop + 16'd1;
            end
        end
    end

    assign stat_frm_cnt  = r_stat_frm;
    assign stat_drop_cnt = r_stat_drop;
`else
    // Statistics counters are not built in this configuration.
`endif

    assign frm_avail  = w_avail;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign drop_pulse = r_drop_pulse;
    assign free_words = r_free;

endmodule

// File: tb/tb_mac_pkt_buf.sv
// tb_mac_pkt_buf: directed, table-driven bench for mac_pkt_buf (default
// parameters, statistics macro undefined). A frame table covers commit/drop
// decisions at the length boundaries; hand-written sequences cover the
// multi-frame corner cases (skip on release, length FIFO full, RAM overflow,
// reset mid-frame).

module tb_mac_pkt_buf;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic        in_err;
    logic [2:0]  in_bytes;
    logic [31:0] in_data;
    logic        frm_avail;
    logic [10:0] frm_len;
    logic        rd_req;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        frm_done;
    logic        drop_pulse;
    logic [9:0]  free_words;

    int totalCount = 0;
    int passCount  = 0;
    int dropSeen   = 0;

    typedef struct {
        string name;
        int    len;
        bit    wren;
        int    errBeat;
        bit    expCommit;
    } frame_vec_t;

    frame_vec_t vecs[11];

    mac_pkt_buf dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_last    (in_last),
        .in_err     (in_err),
        .in_bytes   (in_bytes),
        .in_data    (in_data),
        .frm_avail  (frm_avail),
        .frm_len    (frm_len),
        .rd_req     (rd_req),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .frm_done   (frm_done),
        .drop_pulse (drop_pulse),
        .free_words (free_words)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count drop pulses mid-cycle so back-to-back frames can be tallied
    always @(negedge clk) begin
        if (drop_pulse === 1'b1) dropSeen <= dropSeen + 1;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] pat(input int id, input int w);
        logic [7:0]  idb;
        logic [15:0] wb;
        idb = id[7:0];
        wb  = w[15:0];
        return {8'hA5 ^ idb, idb, wb};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one whole frame, one beat per cycle; optionally release the head
    // frame during the last beat
    task automatic applyStimulus(input int len, input int id, input bit wren,
                                 input int errBeat, input bit doneOnLast);
        int beats;
        beats = (len + 3) / 4;
        for (int b = 0; b < beats; b++) begin
            in_valid = 1'b1;
            in_first = (b == 0);
            in_last  = (b == beats - 1);
            in_err   = (b == errBeat);
            in_bytes = (b == beats - 1) ? 3'(len - 4 * (beats - 1)) : 3'd4;
            wr_en    = wren;
            in_data  = pat(id, b);
            frm_done = doneOnLast && (b == beats - 1);
            tick();
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_err   = 1'b0;
        in_bytes = 3'd4;
        in_data  = '0;
        frm_done = 1'b0;
    endtask

    task automatic readWords(input int id, input int first, input int n);
        for (int w = 0; w < n; w++) begin
            rd_req = 1'b1;
            tick();
            checkOutput($sformatf("rd_valid id%0d w%0d", id, first + w), {31'd0, rd_valid}, 32'd1);
            checkOutput($sformatf("rd_data id%0d w%0d", id, first + w), rd_data, pat(id, first + w));
        end
        rd_req = 1'b0;
    endtask

    task automatic readExcess(input string name);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        checkOutput(name, {31'd0, rd_valid}, 32'd0);
    endtask

    task automatic releaseFrame;
        frm_done = 1'b1;
        tick();
        frm_done = 1'b0;
    endtask

    initial begin
        int d0;
        int words;

        vecs[0]  = '{"64B good",       64, 1'b1, -1, 1'b1};
        vecs[1]  = '{"40B short",      40, 1'b1, -1, 1'b0};
        vecs[2]  = '{"1600B long",   1600, 1'b1, -1, 1'b0};
        vecs[3]  = '{"100B err b5",   100, 1'b1,  5, 1'b0};
        vecs[4]  = '{"100B good",     100, 1'b1, -1, 1'b1};
        vecs[5]  = '{"60B min",        60, 1'b1, -1, 1'b1};
        vecs[6]  = '{"59B under",      59, 1'b1, -1, 1'b0};
        vecs[7]  = '{"1518B max",    1518, 1'b1, -1, 1'b1};
        vecs[8]  = '{"1519B over",   1519, 1'b1, -1, 1'b0};
        vecs[9]  = '{"64B wr_en=0",    64, 1'b0, -1, 1'b0};
        vecs[10] = '{"61B odd",        61, 1'b1, -1, 1'b1};

        rst      = 1'b1;
        wr_en    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_err   = 1'b0;
        in_bytes = 3'd4;
        in_data  = '0;
        rd_req   = 1'b0;
        frm_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("reset frm_avail",  {31'd0, frm_avail}, 32'd0);
        checkOutput("reset frm_len",    {21'd0, frm_len}, 32'd0);
        checkOutput("reset rd_valid",   {31'd0, rd_valid}, 32'd0);
        checkOutput("reset rd_data",    rd_data, 32'd0);
        checkOutput("reset drop_pulse", {31'd0, drop_pulse}, 32'd0);
        checkOutput("reset free_words", {22'd0, free_words}, 32'd512);

        // Three bad frames back to back, then a good one from address 0
        d0 = dropSeen;
        applyStimulus(40, 1, 1'b1, -1, 1'b0);
        applyStimulus(1600, 2, 1'b1, -1, 1'b0);
        applyStimulus(100, 3, 1'b1, 5, 1'b0);
        tick();
        tick();
        checkOutput("3 bad drops",     dropSeen - d0, 32'd3);
        checkOutput("3 bad frm_avail", {31'd0, frm_avail}, 32'd0);
        checkOutput("3 bad free",      {22'd0, free_words}, 32'd512);
        applyStimulus(100, 4, 1'b1, -1, 1'b0);
        checkOutput("100B frm_avail", {31'd0, frm_avail}, 32'd1);
        checkOutput("100B frm_len",   {21'd0, frm_len}, 32'd100);
        tick();
        checkOutput("100B free", {22'd0, free_words}, 32'd487);
        readWords(4, 0, 25);
        readExcess("100B excess rd_valid");
        releaseFrame();
        checkOutput("100B done frm_avail", {31'd0, frm_avail}, 32'd0);
        tick();
        checkOutput("100B done free", {22'd0, free_words}, 32'd512);

        // Frame table
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].len, 10 + i, vecs[i].wren, vecs[i].errBeat, 1'b0);
            checkOutput({vecs[i].name, " drop_pulse"}, {31'd0, drop_pulse}, {31'd0, ~vecs[i].expCommit});
            checkOutput({vecs[i].name, " frm_avail"}, {31'd0, frm_avail}, {31'd0, vecs[i].expCommit});
            if (vecs[i].expCommit) begin
                checkOutput({vecs[i].name, " frm_len"}, {21'd0, frm_len}, vecs[i].len);
                words = (vecs[i].len + 3) / 4;
                readWords(10 + i, 0, words);
                readExcess({vecs[i].name, " excess rd_valid"});
                releaseFrame();
                checkOutput({vecs[i].name, " done frm_avail"}, {31'd0, frm_avail}, 32'd0);
            end
            tick();
            checkOutput({vecs[i].name, " free"}, {22'd0, free_words}, 32'd512);
        end

        // Releasing a 61-byte frame with words unread skips to the next frame
        applyStimulus(61, 30, 1'b1, -1, 1'b0);
        checkOutput("skip frm_len", {21'd0, frm_len}, 32'd61);
        readWords(30, 0, 13);
        releaseFrame();
        checkOutput("skip frm_avail", {31'd0, frm_avail}, 32'd0);
        applyStimulus(64, 31, 1'b1, -1, 1'b0);
        checkOutput("skip next frm_len", {21'd0, frm_len}, 32'd64);
        readWords(31, 0, 2);
        releaseFrame();
        tick();
        checkOutput("skip free", {22'd0, free_words}, 32'd512);

        // Five frames into a four-entry length FIFO; release on the 5th last beat
        d0 = dropSeen;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(64, 40 + k, 1'b1, -1, (k == 4));
        end
        tick();
        checkOutput("fifo full drops",   dropSeen - d0, 32'd1);
        checkOutput("fifo full avail",   {31'd0, frm_avail}, 32'd1);
        checkOutput("fifo full frm_len", {21'd0, frm_len}, 32'd64);
        readWords(41, 0, 1);
        rd_req   = 1'b1;
        frm_done = 1'b1;
        tick();
        rd_req   = 1'b0;
        frm_done = 1'b0;
        checkOutput("done beats rd_req", {31'd0, rd_valid}, 32'd0);
        checkOutput("after pop avail",   {31'd0, frm_avail}, 32'd1);
        readWords(42, 0, 1);
        releaseFrame();
        checkOutput("last entry avail", {31'd0, frm_avail}, 32'd1);
        releaseFrame();
        checkOutput("empty avail", {31'd0, frm_avail}, 32'd0);
        tick();
        checkOutput("fifo seq free", {22'd0, free_words}, 32'd512);

        // RAM overflow with two 1500-byte frames
        d0 = dropSeen;
        applyStimulus(1500, 50, 1'b1, -1, 1'b0);
        checkOutput("1500 first avail", {31'd0, frm_avail}, 32'd1);
        applyStimulus(1500, 51, 1'b1, -1, 1'b0);
        tick();
        checkOutput("overflow drops",   dropSeen - d0, 32'd1);
        checkOutput("overflow free",    {22'd0, free_words}, 32'd137);
        checkOutput("overflow frm_len", {21'd0, frm_len}, 32'd1500);
        releaseFrame();
        applyStimulus(1500, 52, 1'b1, -1, 1'b0);
        checkOutput("1500 third drop_pulse", {31'd0, drop_pulse}, 32'd0);
        checkOutput("1500 third avail",      {31'd0, frm_avail}, 32'd1);
        readWords(52, 0, 3);
        releaseFrame();
        tick();
        checkOutput("overflow seq free", {22'd0, free_words}, 32'd512);

        // Reset in the middle of a frame while another frame is queued
        applyStimulus(64, 60, 1'b1, -1, 1'b0);
        checkOutput("pre-reset avail", {31'd0, frm_avail}, 32'd1);
        d0 = dropSeen;
        for (int b = 0; b < 16; b++) begin
            in_valid = 1'b1;
            in_first = (b == 0);
            in_last  = (b == 15);
            in_bytes = 3'd4;
            in_data  = pat(61, b);
            wr_en    = 1'b1;
            rst      = (b == 10);
            tick();
            if (b == 10) begin
                checkOutput("mid reset avail",      {31'd0, frm_avail}, 32'd0);
                checkOutput("mid reset frm_len",    {21'd0, frm_len}, 32'd0);
                checkOutput("mid reset rd_valid",   {31'd0, rd_valid}, 32'd0);
                checkOutput("mid reset drop_pulse", {31'd0, drop_pulse}, 32'd0);
                checkOutput("mid reset free",       {22'd0, free_words}, 32'd512);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        tick();
        checkOutput("tail ignored avail", {31'd0, frm_avail}, 32'd0);
        checkOutput("tail ignored drops", dropSeen - d0, 32'd0);
        applyStimulus(64, 62, 1'b1, -1, 1'b0);
        checkOutput("post reset avail",   {31'd0, frm_avail}, 32'd1);
        checkOutput("post reset frm_len", {21'd0, frm_len}, 32'd64);
        readWords(62, 0, 16);
        releaseFrame();
        tick();
        checkOutput("post reset free", {22'd0, free_words}, 32'd512);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
